k005297_pgcmp: RTL and testbench

// - Downstream consumer of the bit-serial absolute page counter. It deserialises the 12-bit

---
 rtl/k005297_pgcmp.sv | 163 ++++++++++++++++
 tb/tb_k005297_pgcmp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k005297_pgcmp.sv
// k005297_pgcmp: deserialises the LSB-first page word once per ROT20 frame and runs a target-page search.
// Optional macro K005297_PGCMP_NEAR_EN adds o_PAGE_NEAR (page one frame ahead of the target).
module k005297_pgcmp #(
    parameter int PAGE_W         = 12,
    parameter int PAGE_MAX       = 2052,
    parameter int TIMEOUT_FRAMES = 2100
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CLK2M_PCEN_n,
    input  logic [19:0]       i_ROT20_n,
    input  logic              i_ABSPGCNTR_LSB,
    input  logic [PAGE_W-1:0] i_TARGET_PAGE,
    input  logic              i_SEARCH_START,
    input  logic              i_SEARCH_ABORT,
    output logic [PAGE_W-1:0] o_CUR_PAGE,
    output logic              o_PAGE_MATCH,
`ifdef K005297_PGCMP_NEAR_EN
    output logic              o_PAGE_NEAR,
`endif
    output logic              o_SEARCH_BUSY,
    output logic              o_SEARCH_TIMEOUT,
    output logic              o_SEARCH_ERR
);

    localparam int                CNT_W       = 12;
    localparam logic [PAGE_W-1:0] PAGE_MAX_W  = PAGE_W'(PAGE_MAX);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_FRAMES);

    typedef enum logic [2:0] {IDLE, ARMED, SEARCH, FOUND, TIMEOUT} state_t;

    state_t            state_q, state_d;
    logic [PAGE_W-1:0] shift_q, curPage_q, target_q, target_d;
    logic [CNT_W-1:0]  frameCnt_q, frameCnt_d, frameCntInc;
    logic              timeout_q, timeout_d, err_q, err_d, match_q, match_d;
    logic              en, wordValid, frameEnd, startGo, abortGo, targetBad, compareGo, hit;
    logic              unusedPhases;

    assign en           = ~i_CLK2M_PCEN_n;
    assign wordValid    = en & ~i_ROT20_n[PAGE_W];
    assign frameEnd     = en & ~i_ROT20_n[19];
    assign abortGo      = en & i_SEARCH_ABORT;
    assign startGo      = en & i_SEARCH_START & ~i_SEARCH_ABORT;
    assign targetBad    = i_TARGET_PAGE > PAGE_MAX_W;
    assign compareGo    = (state_q == SEARCH) & wordValid & ~abortGo & ~startGo;
    assign hit          = shift_q == target_q;
    assign frameCntInc  = frameCnt_q + CNT_W'(1);
    assign unusedPhases = &i_ROT20_n[18:PAGE_W+1];

    // Serial capture: phase k deposits bit k, the word is published on the following phase.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            shift_q   <= '0;
            curPage_q <= '0;
        end else if (en) begin
            for (int k = 0; k < PAGE_W; k++) begin
                if (!i_ROT20_n[k]) shift_q[k] <= i_ABSPGCNTR_LSB;
            end
            if (wordValid) curPage_q <= shift_q;
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Abort beats start; start restarts from any state.
    always_comb begin
        state_d = state_q;
        if (abortGo) begin
            state_d = IDLE;
        end else if (startGo) begin
            state_d = targetBad ? IDLE : ARMED;
        end else if (en) begin
            case (state_q)
                ARMED:   if (frameEnd) state_d = SEARCH;
                SEARCH:  if (compareGo) begin
                             if (hit)                              state_d = FOUND;
                             else if (frameCntInc == TIMEOUT_CNT) state_d = TIMEOUT;
                         end
                FOUND:   state_d = IDLE;
                TIMEOUT: state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        target_d   = target_q;
        frameCnt_d = frameCnt_q;
        timeout_d  = timeout_q;
        err_d      = err_q;
        match_d    = en ? 1'b0 : match_q;
        if (startGo) begin
            timeout_d  = 1'b0;
            err_d      = targetBad;
            frameCnt_d = '0;
            if (!targetBad) target_d = i_TARGET_PAGE;
        end else if (compareGo) begin
            match_d = hit;
            if (!hit) begin
                frameCnt_d = frameCntInc;
                if (frameCntInc == TIMEOUT_CNT) timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            target_q   <= '0;
            frameCnt_q <= '0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            target_q   <= target_d;
            frameCnt_q <= frameCnt_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            match_q    <= match_d;
        end
    end

    // FOUND still reads busy so busy falls one enable after the match pulse.
    always_comb begin
        o_SEARCH_BUSY = (state_q == ARMED) || (state_q == SEARCH) || (state_q == FOUND);
    end

    assign o_CUR_PAGE       = curPage_q;
    assign o_PAGE_MATCH     = match_q;
    assign o_SEARCH_TIMEOUT = timeout_q;
    assign o_SEARCH_ERR     = err_q;

`ifdef K005297_PGCMP_NEAR_EN
    // The counter steps +522 mod 2053 per frame, so "near" is the page seen one frame earlier.
    localparam int                PAGE_STEP   = 522;
    localparam logic [PAGE_W:0]   PAGE_COUNT  = (PAGE_W+1)'(PAGE_MAX + 1);
    localparam logic [PAGE_W:0]   NEAR_OFFSET = (PAGE_W+1)'(PAGE_MAX + 1 - PAGE_STEP);

    logic [PAGE_W:0]   nearSum;
    logic [PAGE_W-1:0] nearPage, nearTarget_q, nearTarget_d;
    logic              near_q, near_d;

    assign nearSum      = {1'b0, i_TARGET_PAGE} + NEAR_OFFSET;
    assign nearPage     = PAGE_W'((nearSum >= PAGE_COUNT) ? (nearSum - PAGE_COUNT) : nearSum);
    assign nearTarget_d = (startGo && !targetBad) ? nearPage : nearTarget_q;
    assign near_d       = en ? (compareGo && (shift_q == nearTarget_q)) : near_q;

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            nearTarget_q <= '0;
            near_q       <= 1'b0;
        end else begin
            nearTarget_q <= nearTarget_d;
            near_q       <= near_d;
        end
    end

    assign o_PAGE_NEAR = near_q;
`endif

endmodule

// File: tb/tb_k005297_pgcmp.sv
// tb_k005297_pgcmp: frame-level self-checking bench for k005297_pgcmp, run with a 4-frame timeout.
module tb_k005297_pgcmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcenN;
    logic [19:0] rotN;
    logic        serBit;
    logic [11:0] tgt;
    logic        start;
    logic        abort;
    logic [11:0] curPage;
    logic        match, busy, timeoutFlag, errFlag;
`ifdef K005297_PGCMP_NEAR_EN
    logic        near;
`endif

    int checks   = 0;
    int failures = 0;

    // Per-frame observations recorded by run_frame.
    logic [11:0] c12;
    logic        m12, b12, t12, n12, b13, mOther, bStart, eStart, tStart, bEnd, tEnd, eEnd;

    always #5 clk = ~clk;

    k005297_pgcmp #(.PAGE_W(12), .PAGE_MAX(2052), .TIMEOUT_FRAMES(4)) dut (
        .i_MCLK           (clk),
        .i_RST            (rst),
        .i_CLK2M_PCEN_n   (pcenN),
        .i_ROT20_n        (rotN),
        .i_ABSPGCNTR_LSB  (serBit),
        .i_TARGET_PAGE    (tgt),
        .i_SEARCH_START   (start),
        .i_SEARCH_ABORT   (abort),
        .o_CUR_PAGE       (curPage),
        .o_PAGE_MATCH     (match),
`ifdef K005297_PGCMP_NEAR_EN
        .o_PAGE_NEAR      (near),
`endif
        .o_SEARCH_BUSY    (busy),
        .o_SEARCH_TIMEOUT (timeoutFlag),
        .o_SEARCH_ERR     (errFlag)
    );

    function automatic int nearOf(input int t);
        return (t + 2053 - 522) % 2053;
    endfunction

    // One enabled edge at phase p, then one disabled edge fed with junk that must be ignored.
    task automatic en_cycle(input int p, input logic s, input logic a, input logic b);
        rotN   = ~(20'd1 << p);
        serBit = b;
        start  = s;
        abort  = a;
        pcenN  = 1'b0;
        @(posedge clk); #1;
        pcenN  = 1'b1;
        start  = 1'($urandom);
        abort  = 1'($urandom);
        serBit = 1'($urandom);
        rotN   = ~(20'd1 << $urandom_range(19, 0));
        @(posedge clk); #1;
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    task automatic run_frame(input logic [11:0] page, input int sp, input int ap);
        mOther = 1'b0;
        n12    = 1'b0;
        for (int p = 0; p < 20; p++) begin
            en_cycle(p, p == sp, p == ap, (p < 12) ? page[p] : 1'($urandom));
            if (p == sp) begin
                bStart = busy; eStart = errFlag; tStart = timeoutFlag;
            end
            if (p == 12) begin
                c12 = curPage; m12 = match; b12 = busy; t12 = timeoutFlag;
`ifdef K005297_PGCMP_NEAR_EN
                n12 = near;
`endif
            end else if (match) begin
                mOther = 1'b1;
            end
            if (p == 13) b13 = busy;
            if (p == 19) begin
                bEnd = busy; tEnd = timeoutFlag; eEnd = errFlag;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pcenN = 1'b1; rotN = '1; serBit = 1'b0; tgt = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({curPage, match, busy, timeoutFlag, errFlag} !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {curPage, match, busy, timeoutFlag, errFlag});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_match();
        tgt = 12'd522;
        run_frame(12'd333, 2, -1);
        checks++; if (bStart !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_on_start got=%b exp=1", bStart); end
        checks++; if (m12 !== 1'b0) begin failures++; $display("[TB] FAIL basic_armed_no_compare got=%b exp=0", m12); end
        run_frame(12'd0, -1, -1);
        checks++; if (c12 !== 12'd0) begin failures++; $display("[TB] FAIL basic_cur0 got=%0d exp=0", c12); end
        checks++; if (m12 !== 1'b0 || mOther !== 1'b0) begin failures++; $display("[TB] FAIL basic_frame1_match got=%b/%b exp=0/0", m12, mOther); end
        run_frame(12'd522, -1, -1);
        checks++; if (c12 !== 12'd522) begin failures++; $display("[TB] FAIL basic_cur522 got=%0d exp=522", c12); end
        checks++; if (m12 !== 1'b1) begin failures++; $display("[TB] FAIL basic_match_pulse got=%b exp=1", m12); end
        checks++; if (mOther !== 1'b0) begin failures++; $display("[TB] FAIL basic_match_width got=%b exp=0", mOther); end
        checks++; if (b12 !== 1'b1 || b13 !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_drop got=%b%b exp=10", b12, b13); end
    endtask

    task automatic test_wrap();
        tgt = 12'd0;
        run_frame(12'd777, 0, -1);
        run_frame(12'd1530, -1, -1);
        run_frame(12'd2052, -1, -1);
        checks++; if (c12 !== 12'd2052 || m12 !== 1'b0) begin failures++; $display("[TB] FAIL wrap_2052 got=%0d/%b exp=2052/0", c12, m12); end
`ifdef K005297_PGCMP_NEAR_EN
        checks++; if (n12 !== 1'b0) begin failures++; $display("[TB] FAIL wrap_near_early got=%b exp=0", n12); end
`endif
        run_frame(12'd1531, -1, -1);
        checks++; if (m12 !== 1'b0) begin failures++; $display("[TB] FAIL wrap_1531_match got=%b exp=0", m12); end
`ifdef K005297_PGCMP_NEAR_EN
        checks++; if (n12 !== 1'b1) begin failures++; $display("[TB] FAIL wrap_near_1531 got=%b exp=1", n12); end
`endif
        run_frame(12'd0, -1, -1);
        checks++; if (m12 !== 1'b1 || t12 !== 1'b0) begin failures++; $display("[TB] FAIL wrap_match0 got=%b/%b exp=1/0", m12, t12); end
    endtask

    task automatic test_timeout();
        logic anyMatch;
        logic [11:0] pages [4] = '{12'd100, 12'd200, 12'd300, 12'd400};
        anyMatch = 1'b0;
        tgt = 12'd7;
        run_frame(12'd11, 0, -1);
        for (int i = 0; i < 4; i++) begin
            run_frame(pages[i], -1, -1);
            anyMatch = anyMatch | m12 | mOther;
            checks++;
            if (t12 !== (i == 3) || b12 !== (i != 3)) begin
                failures++;
                $display("[TB] FAIL timeout_frame%0d got=t%b/b%b exp=t%b/b%b", i, t12, b12, i == 3, i != 3);
            end
        end
        checks++; if (anyMatch !== 1'b0) begin failures++; $display("[TB] FAIL timeout_no_match got=%b exp=0", anyMatch); end
        checks++; if (tEnd !== 1'b1 || bEnd !== 1'b0) begin failures++; $display("[TB] FAIL timeout_sticky got=%b/%b exp=1/0", tEnd, bEnd); end
        run_frame(12'd7, 3, -1);
        checks++; if (tStart !== 1'b0 || bStart !== 1'b1) begin failures++; $display("[TB] FAIL timeout_clear got=%b/%b exp=0/1", tStart, bStart); end
        run_frame(12'd7, -1, 0);
        checks++; if (b12 !== 1'b0 || m12 !== 1'b0) begin failures++; $display("[TB] FAIL abort_search got=%b/%b exp=0/0", b12, m12); end
    endtask

    task automatic test_err();
        tgt = 12'd2053;
        run_frame(12'd5, 4, -1);
        checks++; if (eStart !== 1'b1 || bStart !== 1'b0) begin failures++; $display("[TB] FAIL err_set got=%b/%b exp=1/0", eStart, bStart); end
        checks++; if (eEnd !== 1'b1 || bEnd !== 1'b0) begin failures++; $display("[TB] FAIL err_sticky got=%b/%b exp=1/0", eEnd, bEnd); end
        tgt = 12'd5;
        run_frame(12'd9, 2, -1);
        checks++; if (eStart !== 1'b0 || bStart !== 1'b1) begin failures++; $display("[TB] FAIL err_clear got=%b/%b exp=0/1", eStart, bStart); end
        run_frame(12'd5, -1, -1);
        checks++; if (m12 !== 1'b1) begin failures++; $display("[TB] FAIL err_then_match got=%b exp=1", m12); end
        tgt = 12'd2052;
        run_frame(12'd0, 1, -1);
        checks++; if (eStart !== 1'b0 || bStart !== 1'b1) begin failures++; $display("[TB] FAIL max_target_ok got=%b/%b exp=0/1", eStart, bStart); end
        run_frame(12'd2052, -1, -1);
        checks++; if (m12 !== 1'b1) begin failures++; $display("[TB] FAIL max_target_match got=%b exp=1", m12); end
    endtask

    task automatic test_partial_word();
        tgt = 12'd1234;
        run_frame(12'd1234, 6, -1);
        checks++; if (m12 !== 1'b0 || c12 !== 12'd1234) begin failures++; $display("[TB] FAIL partial_ignored got=%b/%0d exp=0/1234", m12, c12); end
        run_frame(12'd1234, -1, -1);
        checks++; if (m12 !== 1'b1) begin failures++; $display("[TB] FAIL partial_next_frame got=%b exp=1", m12); end
    endtask

    task automatic test_rst_mid();
        tgt = 12'd900;
        run_frame(12'd55, 1, -1);
        run_frame(12'd66, -1, -1);
        for (int p = 0; p < 5; p++) en_cycle(p, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({curPage, match, busy, timeoutFlag, errFlag} !== 16'd0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs got=%h exp=0", {curPage, match, busy, timeoutFlag, errFlag});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(12'd900, -1, -1);
        checks++; if (b12 !== 1'b0 || m12 !== 1'b0 || c12 !== 12'd900) begin failures++; $display("[TB] FAIL rst_mid_idle got=%b/%b/%0d exp=0/0/900", b12, m12, c12); end
    endtask

    task automatic test_start_abort();
        tgt = 12'd300;
        run_frame(12'd1, 0, -1);
        run_frame(12'd2, 5, 5);
        checks++; if ({bStart, eStart, tStart} !== 3'b000) begin failures++; $display("[TB] FAIL start_abort_idle got=%b exp=000", {bStart, eStart, tStart}); end
        run_frame(12'd300, -1, -1);
        checks++; if (m12 !== 1'b0 || b12 !== 1'b0) begin failures++; $display("[TB] FAIL start_abort_no_search got=%b/%b exp=0/0", m12, b12); end
    endtask

    task automatic test_back_to_back();
        tgt = 12'd100;
        run_frame(12'd0, 0, -1);
        run_frame(12'd50, -1, -1);
        tgt = 12'd200;
        run_frame(12'd60, 3, -1);
        checks++; if (bStart !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy got=%b exp=1", bStart); end
        run_frame(12'd100, -1, -1);
        checks++; if (m12 !== 1'b0 || b12 !== 1'b1) begin failures++; $display("[TB] FAIL restart_old_target got=%b/%b exp=0/1", m12, b12); end
        run_frame(12'd200, -1, -1);
        checks++; if (m12 !== 1'b1) begin failures++; $display("[TB] FAIL restart_new_target got=%b exp=1", m12); end
    endtask

    // Reference: after arming, the first of up to 4 complete words equal to the target matches;
    // otherwise the 4th word times out. Busy holds through the match pulse.
    task automatic test_random();
        int t, nr, res;
        int pages [4];
        bit found;
        for (int it = 0; it < 25; it++) begin
            t  = $urandom_range(2052, 0);
            nr = nearOf(t);
            for (int i = 0; i < 4; i++) pages[i] = $urandom_range(2052, 0);
            if ($urandom_range(3, 0) != 0) pages[$urandom_range(3, 0)] = nr;
            if ($urandom_range(3, 0) != 0) pages[$urandom_range(3, 0)] = t;
            found = 1'b0;
            res   = 3;
            for (int i = 0; i < 4; i++) begin
                if (!found && pages[i] == t) begin found = 1'b1; res = i; end
            end
            tgt = 12'(t);
            run_frame(12'($urandom_range(4095, 0)), $urandom_range(18, 0), -1);
            checks++; if (bStart !== 1'b1 || m12 !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_arm got=%b/%b exp=1/0", it, bStart, m12); end
            for (int i = 0; i <= res; i++) begin
                run_frame(12'(pages[i]), -1, -1);
                checks++;
                if (c12 !== 12'(pages[i]) || m12 !== (found && i == res) || mOther !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_f%0d got=%0d/%b/%b exp=%0d/%b/0", it, i, c12, m12, mOther, pages[i], found && i == res);
                end
                checks++;
                if (t12 !== (!found && i == 3) || b12 !== (found || i != 3)) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_f%0d_flags got=t%b/b%b exp=t%b/b%b", it, i, t12, b12, !found && i == 3, found || i != 3);
                end
`ifdef K005297_PGCMP_NEAR_EN
                checks++;
                if (n12 !== (pages[i] == nr)) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_f%0d_near got=%b exp=%b", it, i, n12, pages[i] == nr);
                end
`endif
            end
            checks++; if (bEnd !== 1'b0 || tEnd !== !found) begin failures++; $display("[TB] FAIL rand%0d_end got=%b/%b exp=0/%b", it, bEnd, tEnd, !found); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_wrap();
        test_timeout();
        test_err();
        test_partial_word();
        test_rst_mid();
        test_start_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
